fft_frame_capture: RTL and testbench
====================================

Name: fft_frame_capture

Overview:
- AXI4-Stream slave sink for the FFT core output (m_axis_data_* of FFTCore_TopModule).
- Collects one complete N-point frame of 64-bit complex samples into an on-chip buffer and checks tlast framing.
- Holds the frame for random-access readout by the downstream spectrum/magnitude logic, then releases the buffer for the next frame.
- Applies backpressure through tready while a frame is held.

Parameters:
- N_POINTS, 128, transform length and frame depth in beats.
- ADDR_W, 7, buffer address width; equals log2(N_POINTS).
- DATA_W, 64, stream word width; [31:0] real, [63:32] imaginary, both IEEE-754 single.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_axis_tdata  in  DATA_W  FFT output sample.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  sink ready.
- s_axis_tlast  in  1  last beat of frame.
- frame_ready  out  1  complete frame held in buffer.
- frame_release  in  1  single-cycle pulse; consumer finished with the frame.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  bin index.
- rd_re  out  32  real part of the bin.
- rd_im  out  32  imaginary part of the bin.
- rd_valid  out  1  rd_re/rd_im valid.
- frame_count  out  16  number of committed frames.
- err_tlast_unexpected  out  1  one-cycle pulse: tlast arrived early.
- err_tlast_missing  out  1  one-cycle pulse: no tlast on beat N_POINTS-1.

Behaviour:
- Beat acceptance: a beat is accepted when s_axis_tvalid & s_axis_tready.
- Write counter wcnt (ADDR_W+1 bits) is the write address; it increments by 1 per accepted beat.
- Reset values: state CAPTURE, wcnt 0, s_axis_tready 0 during reset then 1, frame_ready 0, rd_valid 0, rd_re/rd_im 0, frame_count 0, both error outputs 0.
- State CAPTURE: s_axis_tready=1.
  - Beat with wcnt<N-1 and tlast=0: store the beat, increment wcnt.
  - Beat with wcnt<N-1 and tlast=1: pulse err_tlast_unexpected, discard the partial frame, set wcnt=0, remain in CAPTURE.
  - Beat with wcnt=N-1 and tlast=1: store the beat, set wcnt=0, increment frame_count (wraps 0xFFFF->0), go to HOLD.
  - Beat with wcnt=N-1 and tlast=0: pulse err_tlast_missing, discard the frame, set wcnt=0, go to RESYNC.
- State RESYNC: s_axis_tready=1; all beats are dropped. A beat with tlast=1 returns the block to CAPTURE on the next cycle. No error pulses are generated in this state.
- State HOLD: s_axis_tready=0 and frame_ready=1. frame_release=1 moves the block to CAPTURE; tready rises and frame_ready falls on the next cycle.
- frame_release outside HOLD is ignored.
- Reads:
  - Synchronous, 1-cycle latency. rd_en=1 in cycle t while in HOLD gives rd_valid=1 in t+1, with rd_re/rd_im = buffer[rd_addr].
  - rd_en outside HOLD gives rd_valid=0 in t+1; rd_re/rd_im hold their previous value.
  - rd_en and frame_release in the same cycle: the read is still serviced.
- Error pulses are exactly 1 cycle wide and never asserted simultaneously.
- Reset mid-operation: the partial or held frame is discarded and all reset values apply. Buffer contents need not be cleared.
- Gaps in tvalid are legal in all states; data order is preserved.

Decomposition:
- Package fft_stream_pkg:
  - N_POINTS, ADDR_W, DATA_W constants.
  - State enum {CAPTURE, HOLD, RESYNC}.
  - RE_LSB=0 and IM_LSB=32 slice constants.
- Sub-module fft_frame_ram: simple dual-port N_POINTS x DATA_W RAM, one write port and one synchronous read port, single clock (aclk). Keeps block-RAM inference clean.

Test Plan:
1. 128 beats with tdata=64'h3F800000 for i<64 and 0 otherwise, tlast on beat 127 -> frame_ready=1 and tready=0 the cycle after beat 127; reads: addr 0 gives rd_re=32'h3F800000, rd_im=0; addr 64 gives rd_re=0; frame_count=1; no error pulses.
2. Hold frame, keep tvalid=1 with new data, pulse frame_release after 20 cycles -> tready=0 for all 20 cycles; the first new beat is accepted the cycle after the release; the second frame is committed with frame_count=2.
3. tlast on beat 10, then a clean 128-beat frame -> err_tlast_unexpected pulses once at beat 10; frame_ready is not asserted for the short frame; the clean frame commits with frame_count=1.
4. 132 beats with tlast only on beat 131 -> err_tlast_missing pulses at beat 127; beats 128-131 are dropped; frame_count=0; the next clean frame commits.
5. areset=1 for one cycle at beat 50 of a frame, then a clean frame -> all outputs return to reset values; the clean frame commits with frame_count=1 and correct data at addresses 0, 63, 64 and 127.
6. tvalid toggled every cycle, with tdata = beat index -> after commit, reading addr k returns rd_re=k for all k in 0..127.

Source files
------------

// File: rtl/fft_stream_pkg.sv
// Shared constants and state encoding for the FFT output frame capture path.
package fft_stream_pkg;
  localparam int N_POINTS = 128;
  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 64;
  localparam int RE_LSB   = 0;
  localparam int IM_LSB   = 32;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    HOLD    = 2'd1,
    RESYNC  = 2'd2
  } fft_state_e;
endpackage

// File: rtl/fft_frame_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port, single clock.
module fft_frame_ram
  import fft_stream_pkg::*;
(
  input  logic              aclk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [N_POINTS];
  logic [DATA_W-1:0] r_rdata;

  // Read data only updates on a read, so the last result stays on o_rdata.
  always_ff @(posedge aclk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/fft_frame_capture.sv
// AXI4-Stream sink that captures one tlast-framed N-point FFT frame and holds it for readout.
// Handshake: a beat moves only in a cycle where s_axis_tvalid and s_axis_tready are both high.
module fft_frame_capture
  import fft_stream_pkg::*;
(
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  output logic              frame_ready,
  input  logic              frame_release,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_re,
  output logic [31:0]       rd_im,
  output logic              rd_valid,
  output logic [15:0]       frame_count,
  output logic              err_tlast_unexpected,
  output logic              err_tlast_missing,
  output fft_state_e        dbg_state
);
  localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W+1)'(N_POINTS - 1);

  fft_state_e        r_state;
  logic [ADDR_W:0]   r_wcnt;
  logic [15:0]       r_frame_count;
  logic              r_err_unexp;
  logic              r_err_miss;
  logic              r_rd_valid;
  logic              r_rd_loaded;
  logic              w_accept;
  logic              w_last_slot;
  logic              w_store;
  logic              w_rd_fire;
  logic [DATA_W-1:0] w_rdata;

  assign s_axis_tready = !areset && (r_state != HOLD);
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_last_slot   = (r_wcnt == LAST_SLOT);
  // Store only beats whose tlast agrees with their slot; misframed beats never reach the RAM.
  assign w_store       = w_accept && (r_state == CAPTURE) && (w_last_slot == s_axis_tlast);
  assign w_rd_fire     = rd_en && (r_state == HOLD);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state       <= CAPTURE;
      r_wcnt        <= '0;
      r_frame_count <= '0;
      r_err_unexp   <= 1'b0;
      r_err_miss    <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_rd_loaded   <= 1'b0;
    end else begin
      r_err_unexp <= 1'b0;
      r_err_miss  <= 1'b0;
      r_rd_valid  <= w_rd_fire;
      if (w_rd_fire) r_rd_loaded <= 1'b1;
      case (r_state)
        CAPTURE: begin
          if (w_accept) begin
            if (!w_last_slot) begin
              if (s_axis_tlast) begin
                r_err_unexp <= 1'b1;
                r_wcnt      <= '0;
              end else begin
                r_wcnt <= r_wcnt + 1'b1;
              end
            end else begin
              r_wcnt <= '0;
              if (s_axis_tlast) begin
                r_frame_count <= r_frame_count + 16'd1;
                r_state       <= HOLD;
              end else begin
                r_err_miss <= 1'b1;
                r_state    <= RESYNC;
              end
            end
          end
        end
        RESYNC: begin
          if (w_accept && s_axis_tlast) r_state <= CAPTURE;
        end
        HOLD: begin
          if (frame_release) r_state <= CAPTURE;
        end
        default: r_state <= CAPTURE;
      endcase
    end
  end

  fft_frame_ram u_ram (
    .aclk    (aclk),
    .i_we    (w_store),
    .i_waddr (r_wcnt[ADDR_W-1:0]),
    .i_wdata (s_axis_tdata),
    .i_re    (w_rd_fire),
    .i_raddr (rd_addr),
    .o_rdata (w_rdata)
  );

  // Until the first serviced read after reset the read port shows zero.
  assign rd_re                = r_rd_loaded ? w_rdata[RE_LSB +: 32] : 32'd0;
  assign rd_im                = r_rd_loaded ? w_rdata[IM_LSB +: 32] : 32'd0;
  assign rd_valid             = r_rd_valid;
  assign frame_ready          = (r_state == HOLD);
  assign frame_count          = r_frame_count;
  assign err_tlast_unexpected = r_err_unexp;
  assign err_tlast_missing    = r_err_miss;
  assign dbg_state            = r_state;
endmodule

// File: tb/tb_fft_frame_capture.sv
// Directed and randomized bench for fft_frame_capture, checked against a frame-level queue model.
module tb_fft_frame_capture;
  import fft_stream_pkg::*;

  logic              aclk = 1'b0;
  logic              areset;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              s_axis_tlast;
  logic              frame_ready;
  logic              frame_release;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_re;
  logic [31:0]       rd_im;
  logic              rd_valid;
  logic [15:0]       frame_count;
  logic              err_tlast_unexpected;
  logic              err_tlast_missing;
  fft_state_e        dbg_state;

  always #5 aclk = ~aclk;

  fft_frame_capture dut (
    .aclk                 (aclk),
    .areset               (areset),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tlast         (s_axis_tlast),
    .frame_ready          (frame_ready),
    .frame_release        (frame_release),
    .rd_en                (rd_en),
    .rd_addr              (rd_addr),
    .rd_re                (rd_re),
    .rd_im                (rd_im),
    .rd_valid             (rd_valid),
    .frame_count          (frame_count),
    .err_tlast_unexpected (err_tlast_unexpected),
    .err_tlast_missing    (err_tlast_missing),
    .dbg_state            (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the frame in progress is a queue of beats; a full frame is copied to m_buf.
  logic [DATA_W-1:0] m_buf [N_POINTS];
  logic [DATA_W-1:0] m_frame [$];
  bit                m_held;
  bit                m_drop;
  logic [15:0]       m_count;
  logic [31:0]       m_re;
  logic [31:0]       m_im;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0;
    m_drop = 1'b0;
    m_count = 16'd0;
    m_re = 32'd0;
    m_im = 32'd0;
    m_frame.delete();
  endtask

  task automatic model_beat(input logic [63:0] d, input bit last, output bit e_unexp, output bit e_miss);
    e_unexp = 1'b0;
    e_miss  = 1'b0;
    if (m_drop) begin
      if (last) m_drop = 1'b0;
    end else begin
      m_frame.push_back(d);
      if (m_frame.size() == N_POINTS) begin
        if (last) begin
          for (int i = 0; i < N_POINTS; i++) m_buf[i] = m_frame[i];
          m_count = m_count + 16'd1;
          m_held = 1'b1;
        end else begin
          e_miss = 1'b1;
          m_drop = 1'b1;
        end
        m_frame.delete();
      end else if (last) begin
        e_unexp = 1'b1;
        m_frame.delete();
      end
    end
  endtask

  // One clock cycle of stimulus with every observable output checked against the model.
  task automatic cycle(input bit v, input logic [63:0] d, input bit last, input bit rel,
                       input bit ren, input logic [ADDR_W-1:0] ra);
    bit acc, exp_rv, e_unexp, e_miss;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    frame_release = rel;
    rd_en         = ren;
    rd_addr       = ra;
    @(negedge aclk);
    chk("tready", {63'd0, s_axis_tready}, {63'd0, !m_held});
    acc    = v && !m_held;
    exp_rv = ren && m_held;
    @(posedge aclk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    frame_release = 1'b0;
    rd_en         = 1'b0;
    e_unexp = 1'b0;
    e_miss  = 1'b0;
    if (acc) model_beat(d, last, e_unexp, e_miss);
    else if (rel && m_held) m_held = 1'b0;
    if (exp_rv) begin
      m_re = m_buf[ra][31:0];
      m_im = m_buf[ra][63:32];
    end
    chk("err_unexpected", {63'd0, err_tlast_unexpected}, {63'd0, e_unexp});
    chk("err_missing", {63'd0, err_tlast_missing}, {63'd0, e_miss});
    chk("frame_ready", {63'd0, frame_ready}, {63'd0, m_held});
    chk("frame_count", {48'd0, frame_count}, {48'd0, m_count});
    chk("rd_valid", {63'd0, rd_valid}, {63'd0, exp_rv});
    chk("rd_re", {32'd0, rd_re}, {32'd0, m_re});
    chk("rd_im", {32'd0, rd_im}, {32'd0, m_im});
  endtask

  task automatic do_reset();
    areset        = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    frame_release = 1'b0;
    rd_en         = 1'b0;
    @(negedge aclk);
    chk("tready_in_reset", {63'd0, s_axis_tready}, 64'd0);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    model_reset();
    chk("rst_state", {62'd0, dbg_state}, {62'd0, CAPTURE});
    chk("rst_frame_ready", {63'd0, frame_ready}, 64'd0);
    chk("rst_frame_count", {48'd0, frame_count}, 64'd0);
    chk("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    chk("rst_rd_re", {32'd0, rd_re}, 64'd0);
    chk("rst_rd_im", {32'd0, rd_im}, 64'd0);
    chk("rst_err_unexpected", {63'd0, err_tlast_unexpected}, 64'd0);
    chk("rst_err_missing", {63'd0, err_tlast_missing}, 64'd0);
  endtask

  // kind: 0 random, 1 ones-then-zeros pattern, 2 beat index. gap: 0 none, 1 toggle, 2 random.
  task automatic send_frame(input int n, input int last_at, input int kind, input int gap);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0))
        cycle(1'b0, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0, '0);
      case (kind)
        1:       d = (i < 64) ? 64'h0000_0000_3F80_0000 : 64'd0;
        2:       d = 64'(i);
        default: d = {$urandom, $urandom};
      endcase
      cycle(1'b1, d, (i == last_at), 1'b0, 1'b0, '0);
    end
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, a);
  endtask

  task automatic release_frame();
    cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  initial begin
    areset = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tlast = 1'b0;
    frame_release = 1'b0;
    rd_en = 1'b0;
    rd_addr = '0;
    model_reset();

    // 1: patterned frame, then reads of the two halves
    do_reset();
    send_frame(128, 127, 1, 0);
    rd(7'd0);
    chk("t1_re_bin0", {32'd0, rd_re}, 64'h3F80_0000);
    chk("t1_im_bin0", {32'd0, rd_im}, 64'd0);
    rd(7'd64);
    chk("t1_re_bin64", {32'd0, rd_re}, 64'd0);
    chk("t1_count", {48'd0, frame_count}, 64'd1);

    // 2: backpressure while held, release coincident with a read, second frame
    for (int i = 0; i < 20; i++) cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 64'd0, 1'b0, 1'b1, 1'b1, 7'd5);
    send_frame(128, 127, 0, 2);
    chk("t2_count", {48'd0, frame_count}, 64'd2);
    for (int i = 0; i < 8; i++) rd(7'($urandom_range(0, 127)));
    release_frame();
    rd(7'd3);
    release_frame();

    // 3: early tlast, then a clean frame
    do_reset();
    send_frame(11, 10, 0, 0);
    send_frame(128, 127, 0, 2);
    chk("t3_count", {48'd0, frame_count}, 64'd1);
    for (int i = 0; i < 6; i++) rd(7'($urandom_range(0, 127)));
    release_frame();

    // 4: missing tlast, resync on late tlast, then a clean frame
    do_reset();
    send_frame(132, 131, 0, 0);
    chk("t4_count_after_bad", {48'd0, frame_count}, 64'd0);
    send_frame(128, 127, 0, 0);
    for (int i = 0; i < 6; i++) rd(7'($urandom_range(0, 127)));
    release_frame();

    // 5: reset in the middle of a frame
    do_reset();
    send_frame(50, -1, 0, 0);
    do_reset();
    send_frame(128, 127, 0, 2);
    chk("t5_count", {48'd0, frame_count}, 64'd1);
    rd(7'd0);
    rd(7'd63);
    rd(7'd64);
    rd(7'd127);
    release_frame();

    // 6: toggled tvalid with index data; read outside hold first
    do_reset();
    rd(7'd9);
    send_frame(128, 127, 2, 1);
    for (int k = 0; k < N_POINTS; k++) begin
      rd(7'(k));
      chk("t6_re_index", {32'd0, rd_re}, 64'(k));
    end
    release_frame();
    rd(7'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
